// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, PC-select encoding, PC sequencer states.
package cpu_types_pkg;

  localparam int unsigned CPU_WORD_W = 32;

  typedef logic [CPU_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    PC_NPC  = 2'd0,
    PC_BR   = 2'd1,
    PC_JUMP = 2'd2,
    PC_JR   = 2'd3
  } pcsel_t;

  typedef enum logic [1:0] {
    IFETCH = 2'd0,
    DMEM   = 2'd1,
    HALT   = 2'd2
  } pcseq_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC target mux: sequential, branch, jump and register-jump targets.
// Ports:
//   npc      - pc+4 from the PC register
//   pc_sel   - target select
//   br_taken - branch condition, qualifies PC_BR
//   imm16    - branch offset in words
//   jaddr    - jump target field
//   rs_data  - register target for JR
//   target   - selected next PC (wraps mod 2^WORD_W)
module pc_target_calc
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0] npc,
  input  pcsel_t            pc_sel,
  input  logic              br_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jaddr,
  input  logic [WORD_W-1:0] rs_data,
  output logic [WORD_W-1:0] target
);

  logic [WORD_W-1:0] w_br_off;

  // Word offset sign-extended and scaled to bytes.
  assign w_br_off = {{(WORD_W-18){imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = npc;
    case (pc_sel)
      PC_NPC:  target = npc;
      PC_BR:   target = br_taken ? (npc + w_br_off) : npc;
      PC_JUMP: target = {npc[WORD_W-1 -: 4], jaddr, 2'b00};
      PC_JR:   target = rs_data;
      default: target = npc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: generates PC load enable/value and memory
// request enables; holds the PC across data wait states, sticks after HALT.
// Optional macro PCSEQ_PERF_EN adds cyc_cnt/instr_cnt/stall_cnt counters.
// Ports:
//   CLK, nRST                 - clock, async active-low reset
//   pc, npc                   - current PC and pc+4
//   pc_sel, br_taken, imm16,
//   jaddr, rs_data            - target selection inputs
//   mem_rd, mem_wr, halt_in   - decoded instruction class
//   ihit, dhit                - fetch / data access complete
//   PCEN, NewPC               - PC register load enable and value
//   iREN, dREN, dWEN          - memory requests
//   halt                      - sticky halted flag
module pc_sequencer
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W           = 32,
  parameter bit          HALT_ON_MISALIGN = 1'b0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] npc,
  input  pcsel_t            pc_sel,
  input  logic              br_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jaddr,
  input  logic [WORD_W-1:0] rs_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              halt_in,
  input  logic              ihit,
  input  logic              dhit,
  output logic              PCEN,
  output logic [WORD_W-1:0] NewPC,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              halt
`ifdef PCSEQ_PERF_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       instr_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  pcseq_state_t      r_state, w_state_nxt;
  logic [WORD_W-1:0] r_pend_pc, w_pend_nxt;
  logic              r_dren, w_dren_nxt;
  logic              r_dwen, w_dwen_nxt;
  logic              r_halt, w_halt_nxt;
  logic [WORD_W-1:0] w_target;
  logic              w_misalign;
  logic              w_halt_req;
  logic              w_unused_pc;

  // Current PC is not needed: all targets derive from npc or rs_data.
  assign w_unused_pc = ^pc;

  pc_target_calc #(.WORD_W(WORD_W)) u_target (
    .npc      (npc),
    .pc_sel   (pc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .jaddr    (jaddr),
    .rs_data  (rs_data),
    .target   (w_target)
  );

  // Misaligned JR target may be promoted to a halt.
  assign w_misalign = HALT_ON_MISALIGN && (pc_sel == PC_JR) && (rs_data[1:0] != 2'b00);
  assign w_halt_req = halt_in | w_misalign;

  // State and pending-access registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IFETCH;
      r_pend_pc <= '0;
      r_dren    <= 1'b0;
      r_dwen    <= 1'b0;
      r_halt    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_pc <= w_pend_nxt;
      r_dren    <= w_dren_nxt;
      r_dwen    <= w_dwen_nxt;
      r_halt    <= w_halt_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_pc;
    w_dren_nxt  = r_dren;
    w_dwen_nxt  = r_dwen;
    w_halt_nxt  = r_halt;
    PCEN        = 1'b0;
    NewPC       = npc;
    iREN        = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    case (r_state)
      IFETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          if (w_halt_req) begin
            w_halt_nxt  = 1'b1;
            w_state_nxt = HALT;
          end else if (mem_rd | mem_wr) begin
            // Load+store together decodes as a store.
            w_pend_nxt  = w_target;
            w_dren_nxt  = mem_rd & ~mem_wr;
            w_dwen_nxt  = mem_wr;
            w_state_nxt = DMEM;
          end else begin
            PCEN  = 1'b1;
            NewPC = w_target;
          end
        end
      end
      DMEM: begin
        dREN  = r_dren;
        dWEN  = r_dwen;
        NewPC = r_pend_pc;
        if (dhit) begin
          PCEN        = 1'b1;
          w_dren_nxt  = 1'b0;
          w_dwen_nxt  = 1'b0;
          w_state_nxt = IFETCH;
        end
      end
      HALT: begin
      end
      default: w_state_nxt = IFETCH;
    endcase
  end

  assign halt = r_halt;

`ifdef PCSEQ_PERF_EN
  logic [31:0] r_cyc_cnt, r_instr_cnt, r_stall_cnt;
  logic        w_halt_entry;

  assign w_halt_entry = (r_state == IFETCH) && (w_state_nxt == HALT);

  // Performance counters, free-running with wrap.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cyc_cnt   <= '0;
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state != HALT) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (PCEN || w_halt_entry) r_instr_cnt <= r_instr_cnt + 32'd1;
      if ((r_state == DMEM) && !dhit) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign cyc_cnt   = r_cyc_cnt;
  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
